// File: rtl/adder_bist_checker.sv
// Purpose: BIST sweep engine that drives every {a,b} pair into the adder, checks {carry,sum} and reports errors.
// Latency: SETTLE+1 cycles per vector, done after (SETTLE+1)*2^(2*WIDTH) edges; no backpressure, start ignored while busy.
// Optional: ADDER_BIST_FAIL_CAPTURE_EN latches the first failing vector into fail_*; otherwise fail_* tie to 0.
module adder_bist_checker #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [0:WIDTH-1]   a,
    output logic [0:WIDTH-1]   b,
    input  logic [WIDTH-1:0]   sum,
    input  logic               carry,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   err_count,
    output logic [WIDTH-1:0]   fail_a,
    output logic [WIDTH-1:0]   fail_b,
    output logic [WIDTH-1:0]   fail_sum,
    output logic               fail_carry
);

    localparam int IW = 2 * WIDTH;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(SETTLE - 1);
    localparam logic [IW-1:0] LAST   = '1;

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  idx_q;
    logic [CW-1:0]  cnt_q;
    logic [IW:0]    err_q;
    logic [WIDTH:0] expected;
    logic           mismatch;
    logic           launch;

    assign launch   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign expected = {1'b0, a} + {1'b0, b};
    assign mismatch = ({carry, sum} != expected);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_SETTLE;
            S_SETTLE:       if (cnt_q == '0) state_d = S_CHECK;
            S_CHECK:        state_d = (idx_q == LAST) ? S_DONE : S_SETTLE;
            default:        state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
            cnt_q <= '0;
            err_q <= '0;
        end else if (launch) begin
            idx_q <= '0;
            cnt_q <= RELOAD;
            err_q <= '0;
        end else if (state_q == S_SETTLE) begin
            if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
        end else if (state_q == S_CHECK) begin
            if (mismatch) err_q <= err_q + (IW+1)'(1);
            // On the last vector the index stays put so a/b hold (all ones) in DONE.
            if (idx_q != LAST) begin
                idx_q <= idx_q + IW'(1);
                cnt_q <= RELOAD;
            end
        end
    end

    assign {a, b}    = idx_q;
    assign busy      = (state_q == S_SETTLE) || (state_q == S_CHECK);
    assign done      = (state_q == S_DONE);
    assign pass      = done && (err_q == '0);
    assign err_count = err_q;

`ifdef ADDER_BIST_FAIL_CAPTURE_EN
    logic [WIDTH-1:0] fa_q, fb_q, fs_q;
    logic             fc_q;

    always_ff @(posedge clk) begin
        if (rst || launch) begin
            fa_q <= '0;
            fb_q <= '0;
            fs_q <= '0;
            fc_q <= 1'b0;
        end else if ((state_q == S_CHECK) && mismatch && (err_q == '0)) begin
            fa_q <= a;
            fb_q <= b;
            fs_q <= sum;
            fc_q <= carry;
        end
    end

    assign fail_a     = fa_q;
    assign fail_b     = fb_q;
    assign fail_sum   = fs_q;
    assign fail_carry = fc_q;
`else
    assign fail_a     = '0;
    assign fail_b     = '0;
    assign fail_sum   = '0;
    assign fail_carry = 1'b0;
`endif

endmodule

// File: tb/tb_adder_bist_checker.sv
// Directed bench for adder_bist_checker: healthy, faulty and pipelined adder models across SETTLE values.
module tb_adder_bist_checker;

`ifdef ADDER_BIST_FAIL_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic start = 1'b0;
    int   fault = 0;
    int   tests = 0;
    int   fails = 0;

    // Main instance (SETTLE=2) on a fault-injectable combinational adder.
    logic [0:3] m_a, m_b;
    logic [3:0] m_sum, m_fa, m_fb, m_fs;
    logic       m_carry, m_busy, m_done, m_pass, m_fc;
    logic [8:0] m_err;

    // SETTLE=1, SETTLE=4 and SETTLE=2 with a 2-cycle-latency adder, all healthy.
    logic [0:3] s1_a, s1_b, s4_a, s4_b, l_a, l_b;
    logic [3:0] s1_sum, s4_sum, l_sum, s1_fa, s1_fb, s1_fs, s4_fa, s4_fb, s4_fs, l_fa, l_fb, l_fs;
    logic       s1_carry, s4_carry, l_carry, s1_busy, s4_busy, l_busy;
    logic       s1_done, s4_done, l_done, s1_pass, s4_pass, l_pass, s1_fc, s4_fc, l_fc;
    logic [8:0] s1_err, s4_err, l_err;
    logic [4:0] p1, p2;

    function automatic logic [4:0] model(input logic [3:0] x, input logic [3:0] y, input int f);
        logic [4:0] r;
        r = {1'b0, x} + {1'b0, y};
        if (f == 1) r[4] = 1'b0;
        if (f == 2) r[0] = 1'b0;
        return r;
    endfunction

    assign {m_carry, m_sum}   = model(m_a, m_b, fault);
    assign {s1_carry, s1_sum} = model(s1_a, s1_b, 0);
    assign {s4_carry, s4_sum} = model(s4_a, s4_b, 0);
    assign {l_carry, l_sum}   = p2;

    always @(posedge clk) begin
        p1 <= model(l_a, l_b, 0);
        p2 <= p1;
    end

    adder_bist_checker #(.WIDTH(4), .SETTLE(2)) dut (
        .clk(clk), .rst(rst), .start(start), .a(m_a), .b(m_b), .sum(m_sum), .carry(m_carry),
        .busy(m_busy), .done(m_done), .pass(m_pass), .err_count(m_err),
        .fail_a(m_fa), .fail_b(m_fb), .fail_sum(m_fs), .fail_carry(m_fc));

    adder_bist_checker #(.WIDTH(4), .SETTLE(1)) dut_s1 (
        .clk(clk), .rst(rst), .start(start), .a(s1_a), .b(s1_b), .sum(s1_sum), .carry(s1_carry),
        .busy(s1_busy), .done(s1_done), .pass(s1_pass), .err_count(s1_err),
        .fail_a(s1_fa), .fail_b(s1_fb), .fail_sum(s1_fs), .fail_carry(s1_fc));

    adder_bist_checker #(.WIDTH(4), .SETTLE(4)) dut_s4 (
        .clk(clk), .rst(rst), .start(start), .a(s4_a), .b(s4_b), .sum(s4_sum), .carry(s4_carry),
        .busy(s4_busy), .done(s4_done), .pass(s4_pass), .err_count(s4_err),
        .fail_a(s4_fa), .fail_b(s4_fb), .fail_sum(s4_fs), .fail_carry(s4_fc));

    adder_bist_checker #(.WIDTH(4), .SETTLE(2)) dut_lat (
        .clk(clk), .rst(rst), .start(start), .a(l_a), .b(l_b), .sum(l_sum), .carry(l_carry),
        .busy(l_busy), .done(l_done), .pass(l_pass), .err_count(l_err),
        .fail_a(l_fa), .fail_b(l_fb), .fail_sum(l_fs), .fail_carry(l_fc));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
    endtask

    // start is sampled at the edge inside this task: that edge is edge 0.
    task automatic pulse_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic run_to_done(input int from, output int n);
        n = from;
        while (!m_done && n < 2000) begin
            tick;
            n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tests++; if ({m_busy, m_done, m_pass} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b expected 000", {m_busy, m_done, m_pass}); end
        tests++; if ({m_a, m_b, m_err} !== 17'd0) begin fails++; $display("FAIL reset_data got a=%0d b=%0d err=%0d expected 0", m_a, m_b, m_err); end
        tests++; if ({m_fa, m_fb, m_fs, m_fc} !== 13'd0) begin fails++; $display("FAIL reset_fail got %h expected 0", {m_fa, m_fb, m_fs, m_fc}); end
        rst = 1'b0;
        start = 1'b0;
        tick;
        tests++; if ({m_busy, m_done} !== 2'b00) begin fails++; $display("FAIL idle_hold got %b expected 00", {m_busy, m_done}); end
    endtask

    task automatic test_correct;
        int n;
        fault = 0;
        do_reset;
        pulse_start;
        tests++; if ({m_busy, m_done} !== 2'b10) begin fails++; $display("FAIL busy_after_start got %b expected 10", {m_busy, m_done}); end
        run_to_done(0, n);
        tests++; if (n != 768) begin fails++; $display("FAIL correct_done_edge got %0d expected 768", n); end
        tests++; if (m_err !== 9'd0 || m_pass !== 1'b1 || m_busy !== 1'b0) begin fails++; $display("FAIL correct_result got err=%0d pass=%b busy=%b expected 0 1 0", m_err, m_pass, m_busy); end
        tests++; if ({m_fa, m_fb, m_fs, m_fc} !== 13'd0) begin fails++; $display("FAIL correct_fail got %h expected 0", {m_fa, m_fb, m_fs, m_fc}); end
        tests++; if (m_a !== 4'd15 || m_b !== 4'd15) begin fails++; $display("FAIL done_hold_ab got a=%0d b=%0d expected 15 15", m_a, m_b); end
    endtask

    task automatic test_carry_stuck;
        int n;
        fault = 1;
        do_reset;
        pulse_start;
        run_to_done(0, n);
        tests++; if (n != 768 || m_err !== 9'd120 || m_pass !== 1'b0) begin fails++; $display("FAIL carry_result got edge=%0d err=%0d pass=%b expected 768 120 0", n, m_err, m_pass); end
        tests++; if (m_fa !== (CAP ? 4'd1 : 4'd0) || m_fb !== (CAP ? 4'd15 : 4'd0) || m_fs !== 4'd0 || m_fc !== 1'b0) begin
            fails++; $display("FAIL carry_first got a=%0d b=%0d s=%0d c=%b expected cap=%b", m_fa, m_fb, m_fs, m_fc, CAP); end
        repeat (5) tick;
        tests++; if (m_done !== 1'b1 || m_err !== 9'd120) begin fails++; $display("FAIL done_hold got done=%b err=%0d expected 1 120", m_done, m_err); end
    endtask

    task automatic test_restart;
        int n;
        pulse_start;
        tests++; if ({m_busy, m_done} !== 2'b10 || m_err !== 9'd0 || {m_fa, m_fb, m_fs, m_fc} !== 13'd0) begin
            fails++; $display("FAIL restart_clear got busy=%b done=%b err=%0d fail=%h expected 1 0 0 0", m_busy, m_done, m_err, {m_fa, m_fb, m_fs, m_fc}); end
        run_to_done(0, n);
        tests++; if (n != 768 || m_err !== 9'd120 || m_fb !== (CAP ? 4'd15 : 4'd0)) begin fails++; $display("FAIL restart_repro got edge=%0d err=%0d fb=%0d expected 768 120", n, m_err, m_fb); end
    endtask

    task automatic test_lsb_stuck;
        int n;
        fault = 2;
        do_reset;
        pulse_start;
        run_to_done(0, n);
        tests++; if (m_err !== 9'd128 || m_pass !== 1'b0) begin fails++; $display("FAIL lsb_result got err=%0d pass=%b expected 128 0", m_err, m_pass); end
        tests++; if (m_fa !== 4'd0 || m_fb !== (CAP ? 4'd1 : 4'd0) || m_fs !== 4'd0 || m_fc !== 1'b0) begin
            fails++; $display("FAIL lsb_first got a=%0d b=%0d s=%0d c=%b expected cap=%b", m_fa, m_fb, m_fs, m_fc, CAP); end
    endtask

    task automatic test_reset_mid;
        int n;
        fault = 1;
        do_reset;
        pulse_start;
        repeat (99) tick;
        tests++; if (m_err !== 9'd1 || m_busy !== 1'b1) begin fails++; $display("FAIL mid_pre got err=%0d busy=%b expected 1 1", m_err, m_busy); end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        tests++; if ({m_busy, m_done, m_pass} !== 3'b000 || m_a !== 4'd0 || m_b !== 4'd0 || m_err !== 9'd0 || {m_fa, m_fb, m_fs, m_fc} !== 13'd0) begin
            fails++; $display("FAIL mid_reset got busy=%b done=%b a=%0d b=%0d err=%0d expected all 0", m_busy, m_done, m_a, m_b, m_err); end
        fault = 0;
        pulse_start;
        run_to_done(0, n);
        tests++; if (n != 768 || m_pass !== 1'b1) begin fails++; $display("FAIL mid_fresh got edge=%0d pass=%b expected 768 1", n, m_pass); end
    endtask

    task automatic test_start_ignored;
        int n;
        fault = 0;
        do_reset;
        pulse_start;
        repeat (49) tick;
        start = 1'b1;
        tick;
        start = 1'b0;
        tests++; if (m_busy !== 1'b1 || m_a !== 4'd1) begin fails++; $display("FAIL busy_start got busy=%b a=%0d expected 1 1", m_busy, m_a); end
        run_to_done(50, n);
        tests++; if (n != 768 || m_pass !== 1'b1) begin fails++; $display("FAIL ignore_start got edge=%0d pass=%b expected 768 1", n, m_pass); end
    endtask

    task automatic test_settle;
        int n1, n4, nl;
        fault = 0;
        do_reset;
        pulse_start;
        n1 = 0; n4 = 0; nl = 0;
        for (int e = 1; e <= 1400; e++) begin
            tick;
            if (s1_done && n1 == 0) n1 = e;
            if (s4_done && n4 == 0) n4 = e;
            if (l_done && nl == 0) nl = e;
        end
        tests++; if (n1 != 512) begin fails++; $display("FAIL settle1_edge got %0d expected 512", n1); end
        tests++; if (n4 != 1280) begin fails++; $display("FAIL settle4_edge got %0d expected 1280", n4); end
        tests++; if (nl != 768 || l_pass !== 1'b1 || l_err !== 9'd0) begin fails++; $display("FAIL latency_adder got edge=%0d pass=%b err=%0d expected 768 1 0", nl, l_pass, l_err); end
        tests++; if (s1_pass !== 1'b1 || s4_pass !== 1'b1 || s1_err !== 9'd0 || s4_err !== 9'd0) begin
            fails++; $display("FAIL settle_pass got p1=%b p4=%b e1=%0d e4=%0d expected 1 1 0 0", s1_pass, s4_pass, s1_err, s4_err); end
        tests++; if ({s1_busy, s4_busy, l_busy, s1_fa, s1_fb, s1_fs, s1_fc, s4_fa, s4_fb, s4_fs, s4_fc, l_fa, l_fb, l_fs, l_fc} !== 42'd0) begin
            fails++; $display("FAIL aux_idle got busy or fail output set, expected 0"); end
    endtask

    initial begin
        test_reset;
        test_correct;
        test_carry_stuck;
        test_restart;
        test_lsb_stuck;
        test_reset_mid;
        test_start_ignored;
        test_settle;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
